// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with a word-by-word line refill from a backing instruction memory.
// Latency: a hit returns data one cycle after the request. A miss costs one REQ cycle, the FILL beats, and then one DELIVER cycle.
// Backpressure: stall holds the requester through REQ/FILL. mem_req is held until mem_ack. FILL waits indefinitely for mem_rvalid.
//
// Ports:
//   clk, rst                   - rising-edge clock, synchronous active-high reset
//   rd_req, addr[31:2]         - fetch request and word address, sampled when rd_req=1 and stall=0 (IDLE only)
//   flush                      - one-cycle pulse that invalidates every line
//   data, data_valid           - fetched word, valid for the last accepted request
//   stall                      - miss in progress (REQ or FILL)
//   mem_req, mem_addr, mem_ack - line refill request handshake; mem_addr is line aligned
//   mem_rvalid, mem_rdata      - refill beats, offsets 0..WORDS-1 in order
//   hits, misses               - saturating event counters
module icache_dm_refill #(
   parameter int IDX_W = 6,
   parameter int OFF_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req,
   input  logic [31:2] addr,
   input  logic        flush,
   output logic [31:0] data,
   output logic        data_valid,
   output logic        stall,
   output logic        mem_req,
   output logic [31:2] mem_addr,
   input  logic        mem_ack,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] hits,
   output logic [31:0] misses
);

   localparam int TAG_W = 30 - IDX_W - OFF_W;
   localparam int LINES = 2**IDX_W;
   localparam int WORDS = 2**OFF_W;

   typedef enum logic [1:0] {IDLE, REQ, FILL, DELIVER} state_t;

   state_t state, state_nxt;

   logic [TAG_W-1:0] a_tag;
   logic [IDX_W-1:0] a_idx;
   logic [OFF_W-1:0] a_off;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tag_arr  [LINES];
   logic [31:0]      data_arr [LINES*WORDS];

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [OFF_W-1:0] req_off;
   logic [OFF_W-1:0] cnt;
   logic             flush_pend;

   logic lookup, hit, miss, beat, last_beat, refilling;

   assign a_tag = addr[31:2+IDX_W+OFF_W];
   assign a_idx = addr[1+IDX_W+OFF_W:2+OFF_W];
   assign a_off = addr[1+OFF_W:2];

   assign lookup    = (state == IDLE) && rd_req;
   assign hit       = lookup && valid[a_idx] && (tag_arr[a_idx] == a_tag);
   assign miss      = lookup && !hit;
   assign refilling = (state == REQ) || (state == FILL);
   assign beat      = (state == FILL) && mem_rvalid;
   assign last_beat = beat && (&cnt);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      mem_req   = 1'b0;
      case (state)
         IDLE:    if (miss) state_nxt = REQ;
         REQ: begin
            stall   = 1'b1;
            mem_req = 1'b1;
            if (mem_ack) state_nxt = FILL;
         end
         FILL: begin
            stall = 1'b1;
            if (last_beat) state_nxt = DELIVER;
         end
         DELIVER: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid      <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         mem_addr   <= '0;
         hits       <= '0;
         misses     <= '0;
         req_tag    <= '0;
         req_idx    <= '0;
         req_off    <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
      end else begin
         data_valid <= 1'b0;

         if (hit) begin
            data       <= data_arr[{a_idx, a_off}];
            data_valid <= 1'b1;
            if (hits != 32'hFFFF_FFFF) hits <= hits + 32'd1;
         end

         if (miss) begin
            req_tag  <= a_tag;
            req_idx  <= a_idx;
            req_off  <= a_off;
            mem_addr <= {a_tag, a_idx, {OFF_W{1'b0}}};
            cnt      <= '0;
            if (misses != 32'hFFFF_FFFF) misses <= misses + 32'd1;
         end

         if (beat) begin
            cnt <= cnt + OFF_W'(1);
            // Capture the requested word as it streams past, so DELIVER needs no array read.
            if (cnt == req_off) data <= mem_rdata;
         end

         if (last_beat) data_valid <= 1'b1;

         // While a refill is in flight, a flush is deferred to the end of the refill.
         // The refilled line must then stay invalid along with every other line.
         if (refilling) begin
            if (last_beat) begin
               if (flush || flush_pend) valid <= '0;
               else                     valid[req_idx] <= 1'b1;
               flush_pend <= 1'b0;
            end else if (flush) begin
               flush_pend <= 1'b1;
            end
         end else if (flush) begin
            // A coincident lookup has already used the pre-flush valid bits.
            valid <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && beat)      data_arr[{req_idx, cnt}] <= mem_rdata;
      if (!rst && last_beat) tag_arr[req_idx]         <= req_tag;
   end

endmodule

// File: tb/tb_icache_dm_refill.sv
// Directed bench for icache_dm_refill with a scoreboard of expected fetch words and a model of the backing memory.
// Latency: not applicable, because this module is a bench.
// Backpressure: the backing-memory responder acks mem_req at once and spaces its beats by 'gap' idle cycles.
module tb_icache_dm_refill;

   logic        clk;
   logic        rst;
   logic        rd_req;
   logic [31:2] addr;
   logic        flush;
   logic [31:0] data;
   logic        data_valid;
   logic        stall;
   logic        mem_req;
   logic [31:2] mem_addr;
   logic        mem_ack;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] hits;
   logic [31:0] misses;

   int checks = 0;
   int errors = 0;
   int gap    = 0;
   logic [31:0] exp_q[$];

   icache_dm_refill dut (
      .clk        (clk),
      .rst        (rst),
      .rd_req     (rd_req),
      .addr       (addr),
      .flush      (flush),
      .data       (data),
      .data_valid (data_valid),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .hits       (hits),
      .misses     (misses)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Contents of the backing instruction memory, indexed by word address.
   function automatic logic [31:0] model(input int wa);
      case (wa)
         0:       return 32'h0000_0293;
         1:       return 32'h0000_0313;
         2:       return 32'h0000_0393;
         3:       return 32'h00a0_0e13;
         default: return 32'h1000_0000 + 32'(wa) * 32'h11;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Backing memory: acks in the cycle mem_req is seen, then streams four beats with 'gap' idle cycles before each beat.
   initial begin
      int rs;
      int bcnt;
      int gc;
      int base;
      rs = 0; bcnt = 0; gc = 0; base = 0;
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack    = 1'b0;
         mem_rvalid = 1'b0;
         case (rs)
            0: if (mem_req === 1'b1) begin
               mem_ack = 1'b1;
               base    = int'({2'b00, mem_addr});
               bcnt    = 0;
               gc      = gap;
               rs      = 1;
            end
            default: begin
               if (gc > 0) gc--;
               else begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = model(base + bcnt);
                  bcnt++;
                  gc = gap;
                  if (bcnt == 4) rs = 0;
               end
            end
         endcase
      end
   end

   // Scoreboard: every data_valid pulse must deliver the oldest outstanding expected word.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (data_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_valid", {31'b0, data_valid}, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("data", data, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // Called at a negedge. Hits leave rd_req asserted so that back-to-back calls form consecutive requests.
   task automatic fetch(input int wa, input bit exp_hit, input int exp_stall,
                        input bit flush_now, input int flush_at);
      int n;
      rd_req = 1'b1;
      addr   = 30'(wa);
      flush  = flush_now;
      exp_q.push_back(model(wa));
      @(negedge clk);
      flush = 1'b0;
      if (exp_hit) begin
         chk("hit_stall", {31'b0, stall}, 32'd0);
         chk("hit_valid", {31'b0, data_valid}, 32'd1);
      end else begin
         chk("miss_stall", {31'b0, stall}, 32'd1);
         chk("miss_dv", {31'b0, data_valid}, 32'd0);
         chk("mem_req", {31'b0, mem_req}, 32'd1);
         chk("mem_addr", {2'b00, mem_addr}, 32'(wa) & ~32'd3);
         n = 0;
         while (stall === 1'b1 && n < 400) begin
            flush = (n == flush_at);
            n++;
            @(negedge clk);
         end
         flush = 1'b0;
         chk("stall_len", n, exp_stall);
         chk("deliver_valid", {31'b0, data_valid}, 32'd1);
         rd_req = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      rd_req = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; rd_req = 1'b0; addr = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", data, 32'd0);
      chk("rst_dv", {31'b0, data_valid}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
      chk("rst_hits", hits, 32'd0);
      chk("rst_misses", misses, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Cold miss on line 0.
      fetch(0, 1'b0, 5, 1'b0, -1);
      chk("cold_misses", misses, 32'd1);
      chk("cold_hits", hits, 32'd0);

      // Line reuse: back-to-back hits.
      fetch(1, 1'b1, 0, 1'b0, -1);
      fetch(2, 1'b1, 0, 1'b0, -1);
      fetch(3, 1'b1, 0, 1'b0, -1);
      idle(1);
      chk("reuse_hits", hits, 32'd3);

      // Conflict on index 0.
      fetch(0, 1'b1, 0, 1'b0, -1);
      fetch(32'h100, 1'b0, 5, 1'b0, -1);
      fetch(0, 1'b0, 5, 1'b0, -1);
      chk("conflict_misses", misses, 32'd3);
      chk("conflict_hits", hits, 32'd4);

      // Gapped refill, then read the whole line back to catch stray writes.
      gap = 3;
      fetch(32'h42, 1'b0, 1 + 4 * (3 + 1), 1'b0, -1);
      gap = 0;
      fetch(32'h40, 1'b1, 0, 1'b0, -1);
      fetch(32'h41, 1'b1, 0, 1'b0, -1);
      fetch(32'h42, 1'b1, 0, 1'b0, -1);
      fetch(32'h43, 1'b1, 0, 1'b0, -1);
      idle(1);
      chk("gap_hits", hits, 32'd8);
      chk("gap_misses", misses, 32'd4);

      // Flush in IDLE.
      fetch(4, 1'b0, 5, 1'b0, -1);
      fetch(4, 1'b1, 0, 1'b0, -1);
      rd_req = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      fetch(4, 1'b0, 5, 1'b0, -1);
      chk("flush_misses", misses, 32'd6);
      // A flush coincident with a lookup: the hit stands and the line is gone afterwards.
      fetch(4, 1'b1, 0, 1'b1, -1);
      fetch(4, 1'b0, 5, 1'b0, -1);
      chk("flush_coinc_hits", hits, 32'd10);
      chk("flush_coinc_misses", misses, 32'd7);

      // Flush during FILL: the word is delivered but the line is not kept.
      fetch(32'h80, 1'b0, 5, 1'b0, 2);
      fetch(32'h80, 1'b0, 5, 1'b0, -1);
      fetch(32'h81, 1'b1, 0, 1'b0, -1);
      idle(1);
      chk("fill_flush_misses", misses, 32'd9);
      chk("fill_flush_hits", hits, 32'd11);

      // Reset after two refill beats. The later beats land during reset and in IDLE.
      rd_req = 1'b1; addr = 30'(32'hC0);
      repeat (4) @(negedge clk);
      chk("midfill_stall", {31'b0, stall}, 32'd1);
      rst = 1'b1; rd_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_fill_stall", {31'b0, stall}, 32'd0);
      chk("rst_fill_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_fill_dv", {31'b0, data_valid}, 32'd0);
      chk("rst_fill_misses", misses, 32'd0);
      @(negedge clk);
      chk("rst_fill_dv2", {31'b0, data_valid}, 32'd0);
      idle(2);
      fetch(32'hC1, 1'b0, 5, 1'b0, -1);
      fetch(32'hC3, 1'b1, 0, 1'b0, -1);
      idle(2);
      chk("refill_misses", misses, 32'd1);
      chk("refill_hits", hits, 32'd1);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
